magnetron_power_controller: RTL

Parametrised successor to the magnetron on/off controller. It adds an internal cook-time countdown, a pause/resume state and a duty-cycled power level. Front-panel keys are active-low: startn, stopn, clearn. mag_on is a time-proportioned enable over a fixed window. It sits between the keypad/door interlock logic and the magnetron driver, and is fed by a 1 Hz-style tick strobe.

---
 rtl/magnetron_power_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/magnetron_power_controller.sv
// rtl/magnetron_power_controller.sv - duty-cycled magnetron controller with cook timer and pause
// Optional soft-start lockout on every COOK entry: define MAGNETRON_SOFTSTART_EN.
module magnetron_power_controller #(
  parameter int LEVELS           = 10,
  parameter int LVL_W            = 4,
  parameter int SLOT_CYCLES      = 4,
  parameter int TIME_W           = 12,
  parameter int SOFTSTART_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              tick,
  input  logic [TIME_W-1:0] time_in,
  input  logic [LVL_W-1:0]  power_in,
  output logic              mag_on,
  output logic              cooking,
  output logic              paused,
  output logic              done,
  output logic [TIME_W-1:0] time_left
);

  localparam int W    = LEVELS * SLOT_CYCLES;
  localparam int PH_W = $clog2(W + 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(W - 1);
  localparam logic [PH_W-1:0]   SLOT_P   = PH_W'(SLOT_CYCLES);
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(LEVELS);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  if ((1 << LVL_W) <= LEVELS) begin : g_lvl_w_check
    $error("LVL_W too narrow for LEVELS");
  end
  if (SOFTSTART_CYCLES < 1) begin : g_softstart_check
    $error("SOFTSTART_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COOK   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              startn_q, stopn_q;
  logic              start_evt, stop_evt, load_ok, load, enter_cook;
  logic [LVL_W-1:0]  power_lat, power_nxt;
  logic [PH_W-1:0]   phase, phase_nxt, thr;
  logic [TIME_W-1:0] time_nxt;
  logic              mag_q, mag_nxt;
  logic              lockout, soft_done_nxt;

  assign start_evt = startn_q & ~startn;
  assign stop_evt  = stopn_q & ~stopn;
  assign load_ok   = door_closed && (time_in != '0) && (power_in != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      time_left <= '0;
      power_lat <= '0;
      phase     <= '0;
      mag_q     <= 1'b0;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      time_left <= time_nxt;
      power_lat <= power_nxt;
      phase     <= phase_nxt;
      mag_q     <= mag_nxt;
      startn_q  <= startn;
      stopn_q   <= stopn;
    end
  end

  // Priority: clear > stop > door open > tick > start.
  always_comb begin
    state_nxt  = state;
    time_nxt   = time_left;
    power_nxt  = power_lat;
    enter_cook = 1'b0;
    load       = 1'b0;
    if (!clearn) begin
      state_nxt = S_IDLE;
      time_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          load = !stop_evt && start_evt && load_ok;
        end
        S_COOK: begin
          if (stop_evt || !door_closed) begin
            state_nxt = S_PAUSED;
          end else if (tick) begin
            if (time_left > TIME_ONE) begin
              time_nxt = time_left - TIME_ONE;
            end else begin
              time_nxt  = '0;
              state_nxt = S_DONE;
            end
          end
        end
        S_PAUSED: begin
          if (stop_evt) begin
            state_nxt = S_IDLE;
            time_nxt  = '0;
          end else if (start_evt && door_closed) begin
            state_nxt  = S_COOK;
            enter_cook = 1'b1;
          end
        end
        S_DONE: begin
          if (stop_evt || !door_closed) begin
            state_nxt = S_IDLE;
            time_nxt  = '0;
          end else begin
            load = start_evt && load_ok;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      if (load) begin
        state_nxt  = S_COOK;
        enter_cook = 1'b1;
        time_nxt   = time_in;
        power_nxt  = (power_in > LVL_MAX) ? LVL_MAX : power_in;
      end
    end
  end

`ifdef MAGNETRON_SOFTSTART_EN
  localparam int SS_W = $clog2(SOFTSTART_CYCLES + 1);
  logic [SS_W-1:0] soft, soft_nxt;

  assign lockout = (soft != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft <= '0;
    end else begin
      soft <= soft_nxt;
    end
  end

  always_comb begin
    soft_nxt = '0;
    if (state_nxt == S_COOK) begin
      if (enter_cook) begin
        soft_nxt = SS_W'(SOFTSTART_CYCLES);
      end else if (lockout) begin
        soft_nxt = soft - 1'b1;
      end
    end
  end

  assign soft_done_nxt = (soft_nxt == '0);
`else
  assign lockout       = 1'b0;
  assign soft_done_nxt = 1'b1;
`endif

  // mag_q is computed from next-cycle phase so it is a clean register aligned with phase.
  assign phase_nxt = (state_nxt != S_COOK || enter_cook || lockout) ? '0 :
                     (phase == PH_LAST) ? '0 : phase + 1'b1;
  assign thr       = PH_W'(power_nxt) * SLOT_P;
  assign mag_nxt   = (state_nxt == S_COOK) && soft_done_nxt && (phase_nxt < thr);

  assign cooking = (state == S_COOK);
  assign paused  = (state == S_PAUSED);
  assign done    = (state == S_DONE);
  assign mag_on  = mag_q & door_closed & cooking;

endmodule
